// File: rtl/adc_frame_pkg.sv
// Shared types and helpers for the ADC frame buffer: writer/reader state
// encodings and the offset-binary to two's-complement conversion.
package adc_frame_pkg;

    typedef enum logic {
        WR_FILL    = 1'b0,
        WR_BLOCKED = 1'b1
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_LOAD   = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_t;

    // Offset-binary to two's complement is an inversion of the sample MSB.
    // Operates on a 32-bit container; callers truncate to their own width.
    function automatic logic [31:0] offset_to_twos(input logic [31:0] sample, input int width);
        return sample ^ (32'd1 << (width - 1));
    endfunction

endpackage

// File: rtl/adc_decimator.sv
// Power-of-two averaging decimator with optional offset-binary conversion.
// Emits one registered sample one cycle after every 2^DECIM_LOG2-th strobe.
module adc_decimator
    import adc_frame_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int DECIM_LOG2 = 0,
    parameter int SIGNED_OUT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    output logic [DATA_W-1:0] dec_data,
    output logic              dec_valid
);

    localparam int ACC_W = DATA_W + DECIM_LOG2;
    localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DECIM_LOG2) - 1);

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] avg;
    logic [DATA_W-1:0] conv;

    // Running sum including the current strobe, truncated average, conversion.
    always_comb begin
        acc_sum = acc + ACC_W'(adc_data);
        avg     = DATA_W'(acc_sum >> DECIM_LOG2);
        conv    = (SIGNED_OUT != 0) ? DATA_W'(offset_to_twos(32'(avg), DATA_W)) : avg;
    end

    // Accumulate strobes; on the last one of a group emit the average and restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            dec_data  <= '0;
            dec_valid <= 1'b0;
        end else begin
            dec_valid <= 1'b0;
            if (adc_valid) begin
                if (cnt == CNT_LAST) begin
                    acc       <= '0;
                    cnt       <= '0;
                    dec_data  <= conv;
                    dec_valid <= 1'b1;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/adc_frame_buffer.sv
// Ping-pong frame buffer: decimated ADC samples fill one bank while the other
// streams out over valid/ready. A full pair of banks blocks the writer, which
// then drops samples and raises a sticky overrun flag.
//
// Read path: pf_data always holds the sample after the one on m_data, so a
// handshake can present the next sample in the following cycle without a
// bubble even though the bank array has a registered read.
module adc_frame_buffer
    import adc_frame_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int FRAME_LEN  = 256,
    parameter int DECIM_LOG2 = 0,
    parameter int SIGNED_OUT = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_W-1:0]            adc_data,
    input  logic                         adc_valid,
    output logic [DATA_W-1:0]            m_data,
    output logic [$clog2(FRAME_LEN)-1:0] m_index,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_last,
    output logic                         overrun,
    output logic [15:0]                  frame_cnt
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] PRE_LAST_IDX = IDX_W'(FRAME_LEN - 2);

    logic [DATA_W-1:0] dec_data;
    logic              dec_valid;

    wr_state_t         wr_state, wr_next;
    rd_state_t         rd_state, rd_next;

    logic              wb;
    logic              rb;
    logic [1:0]        bank_full, bank_full_nxt;
    logic [IDX_W-1:0]  widx;

    logic              wr_en, wr_done, wr_toggle, wr_drop;
    logic              free_other;

    logic              rd_hs, rd_free;
    logic              rd_en, rd_load, rd_adv;
    logic [IDX_W:0]    rd_addr;
    logic [DATA_W-1:0] pf_data;

    logic [DATA_W-1:0] mem [2*FRAME_LEN];

    adc_decimator #(
        .DATA_W     (DATA_W),
        .DECIM_LOG2 (DECIM_LOG2),
        .SIGNED_OUT (SIGNED_OUT)
    ) u_decim (
        .clk       (clk),
        .rst_n     (rst_n),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .dec_data  (dec_data),
        .dec_valid (dec_valid)
    );

    // m_valid is only ever high in RD_STREAM, so these qualify stream events.
    // The bank being freed is always the one the writer is not filling, so a
    // free in the same cycle as a bank completion lets the writer carry on.
    always_comb begin
        rd_hs      = m_valid && m_ready;
        rd_free    = rd_hs && m_last;
        free_other = !bank_full[~wb] || rd_free;
    end

    // ---------------- writer ----------------

    // Writer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_state <= WR_FILL;
        else        wr_state <= wr_next;
    end

    // Writer next state: block when a bank completes and its partner is busy.
    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_FILL:    if (dec_valid && (widx == LAST_IDX) && !free_other) wr_next = WR_BLOCKED;
            WR_BLOCKED: if (free_other) wr_next = WR_FILL;
            default:    wr_next = WR_FILL;
        endcase
    end

    // Writer strobes: write, bank completion, bank switch, dropped sample.
    always_comb begin
        wr_en     = 1'b0;
        wr_done   = 1'b0;
        wr_toggle = 1'b0;
        wr_drop   = 1'b0;
        case (wr_state)
            WR_FILL: begin
                if (dec_valid) begin
                    wr_en = 1'b1;
                    if (widx == LAST_IDX) begin
                        wr_done   = 1'b1;
                        wr_toggle = free_other;
                    end
                end
            end
            WR_BLOCKED: begin
                wr_drop   = dec_valid;
                wr_toggle = free_other;
            end
            default: ;
        endcase
    end

    // Write pointer wraps to 0 on completion; bank select and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            widx    <= '0;
            wb      <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (wr_en)     widx    <= widx + IDX_W'(1);
            if (wr_toggle) wb      <= ~wb;
            if (wr_drop)   overrun <= 1'b1;
        end
    end

    // Bank occupancy: set by the writer, cleared by the reader (never same bank).
    always_comb begin
        bank_full_nxt = bank_full;
        if (wr_done) bank_full_nxt[wb] = 1'b1;
        if (rd_free) bank_full_nxt[rb] = 1'b0;
    end

    // Bank occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bank_full <= 2'b00;
        else        bank_full <= bank_full_nxt;
    end

    // ---------------- reader ----------------

    // Reader state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_state <= RD_IDLE;
        else        rd_state <= rd_next;
    end

    // Reader next state: banks are taken strictly in alternation via rb.
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE:   if (bank_full[rb]) rd_next = RD_LOAD;
            RD_LOAD:   rd_next = RD_STREAM;
            RD_STREAM: if (rd_free) rd_next = bank_full[~rb] ? RD_LOAD : RD_IDLE;
            default:   rd_next = RD_IDLE;
        endcase
    end

    // Reader strobes and bank read address: sample 0 is fetched on entry to
    // LOAD, sample 1 during LOAD, then one sample ahead on every handshake.
    always_comb begin
        rd_en   = 1'b0;
        rd_load = 1'b0;
        rd_adv  = 1'b0;
        rd_addr = '0;
        case (rd_state)
            RD_IDLE: begin
                rd_en   = bank_full[rb];
                rd_addr = {rb, IDX_W'(0)};
            end
            RD_LOAD: begin
                rd_en   = 1'b1;
                rd_load = 1'b1;
                rd_addr = {rb, IDX_W'(1)};
            end
            RD_STREAM: begin
                if (rd_free) begin
                    rd_en   = bank_full[~rb];
                    rd_addr = {~rb, IDX_W'(0)};
                end else if (rd_hs) begin
                    rd_en   = 1'b1;
                    rd_adv  = 1'b1;
                    rd_addr = {rb, m_index + IDX_W'(2)};
                end
            end
            default: ;
        endcase
    end

    // Bank array: synchronous write from the writer, registered prefetch read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[{wb, widx}] <= dec_data;
        if (rd_en) pf_data <= mem[rd_addr];
    end

    // Output register: load first sample, advance on handshake, retire frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb        <= 1'b0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_data    <= '0;
            m_index   <= '0;
            frame_cnt <= '0;
        end else if (rd_load) begin
            m_valid <= 1'b1;
            m_data  <= pf_data;
            m_index <= '0;
            m_last  <= 1'b0;
        end else if (rd_free) begin
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_index   <= '0;
            rb        <= ~rb;
            frame_cnt <= frame_cnt + 16'd1;
        end else if (rd_adv) begin
            m_data  <= pf_data;
            m_index <= m_index + IDX_W'(1);
            m_last  <= (m_index == PRE_LAST_IDX);
        end
    end

endmodule

// File: doc/adc_frame_buffer.md
Name: adc_frame_buffer

Overview:
- Parametrised successor to the single-channel ADC frame reader.
- Accepts strobed ADC samples, optionally decimates them by power-of-two averaging, converts offset-binary to two's complement, and assembles fixed-length frames in a ping-pong buffer.
- Completed frames stream out over valid/ready to the feature-extraction front end (windowing/FFT) while the next frame is captured.
- Overrun is detected and reported instead of silently corrupting frames.

Parameters:
- DATA_W, 12, ADC sample width in bits.
- FRAME_LEN, 256, samples per frame; power of two, ≥4.
- DECIM_LOG2, 0, decimation factor 2^DECIM_LOG2 (0 = none); samples averaged per output sample.
- SIGNED_OUT, 1, 1: output = input XOR MSB (offset-binary to two's complement); 0: pass unsigned.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- adc_data, in, DATA_W, raw ADC sample.
- adc_valid, in, 1, one-cycle strobe qualifying adc_data.
- m_data, out, DATA_W, frame sample out.
- m_index, out, $clog2(FRAME_LEN), sample position within frame.
- m_valid, out, 1, m_data valid.
- m_ready, in, 1, downstream accept.
- m_last, out, 1, high with final sample of frame (index FRAME_LEN-1).
- overrun, out, 1, sticky: a capture was dropped; cleared only by reset.
- frame_cnt, out, 16, frames fully streamed out, wraps at 65535→0.

Behaviour:
- Reset (async assert, sync deassert inside block): m_valid=0, m_last=0, m_data=0, m_index=0, overrun=0, frame_cnt=0, both banks empty, write bank=0, decimator accumulator/counter=0.
- Decimator: on each adc_valid, add adc_data to accumulator of width DATA_W+DECIM_LOG2. On the 2^DECIM_LOG2-th strobe, emit (acc >> DECIM_LOG2), truncating, as one decimated sample and clear acc. DECIM_LOG2=0 emits every strobe. Decimated sample goes through SIGNED_OUT conversion, then to the writer. Latency adc_valid→write: 1 cycle.
- Writer FSM:
  - FILL: each decimated sample written to bank[wb][widx]; widx++. When widx=FRAME_LEN-1 is written, mark bank wb full and reset widx to 0. If the other bank is empty, wb toggles and the FSM stays in FILL; otherwise go to BLOCKED.
  - BLOCKED: decimated samples discarded; the first discard sets overrun. When the reader frees the other bank, toggle wb and return to FILL starting at widx=0. A partial frame is never written.
- Reader FSM:
  - IDLE: if any bank is full (bank 0 first after reset, then strictly alternating), select it as rb, raddr=0, go to LOAD.
  - LOAD: synchronous RAM read, 1 cycle; go to STREAM with m_valid=1, m_index=0.
  - STREAM: m_data/m_index/m_last hold stable while m_valid && !m_ready. On handshake, advance raddr and present the next sample with no bubble (prefetch/skid register required, sustained 1 sample/cycle). On the handshake with m_last: mark rb empty, frame_cnt++, m_valid=0 next cycle unless the other bank is already full, in which case return to LOAD (one-cycle bubble allowed).
- Simultaneous events: the writer completing a bank and the reader freeing the other bank in the same cycle → writer goes to FILL, not BLOCKED, and overrun is not set. A write and a read never target the same bank.
- Mid-operation reset clears everything; a partially captured or streamed frame is discarded.
- m_valid must never drop without a handshake (AXI-stream rule).

Decomposition:
- Package adc_frame_pkg: writer/reader state enums (WR_FILL, WR_BLOCKED; RD_IDLE, RD_LOAD, RD_STREAM) and a function for offset-binary conversion.
- Sub-module adc_decimator (accumulate/shift + sign conversion, outputs sample + valid).
- Banks are a 2*FRAME_LEN x DATA_W synchronous-read array in the top.

Test Plan:
- Ramp, DECIM_LOG2=0, SIGNED_OUT=0, m_ready=1, 512 strobes of 0..511 → two frames: m_data 0..255 then 256..511 (mod 4096), m_last at index 255 each, frame_cnt=2, overrun=0.
- SIGNED_OUT=1, constant input 12'h800 then 12'h000 → m_data 12'h000 then 12'h800 (−2048).
- DECIM_LOG2=2, input 1,2,3,6 repeating → every output sample = 3 (12/4), frame length 256 after 1024 strobes.
- Backpressure: m_ready toggles randomly, adc_valid every 4th cycle → m_data stable while stalled, no sample lost or duplicated, overrun=0.
- Overrun: m_ready=0, continuous adc_valid → banks 0 and 1 fill; the 513th sample sets overrun. Raising m_ready later streams frame A then B intact, and writing resumes at a frame boundary.
- Reset asserted mid-STREAM at index 100 → all outputs return to reset values immediately; after release, the next full frame starts at index 0.
